// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame receiver: FSM encoding, the default
// start-of-frame byte, frame length and the checksum helper.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_DHI = 3'd2,
    GET_DLO = 3'd3,
    GET_CHK = 3'd4
  } state_e;

  localparam logic [7:0]  SOF_DEFAULT = 8'hA5;
  localparam int unsigned FRAME_LEN   = 5;

  // Frame checksum: XOR of the three payload-bearing bytes.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] d_hi,
                                           input logic [7:0] d_lo);
    return cmd ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/uart_frame_rx.sv
// Parses 5-byte frames (SOF, CMD, D_HI, D_LO, CHK) popped from a UART receive
// buffer; reports good frames, checksum errors and inter-byte timeouts.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF         = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 65000,
  parameter int unsigned TO_BIT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_empty,
  input  logic [7:0]  r_data,
  output logic        rd_uart,
  output logic        frame_valid,
  output logic [7:0]  frame_cmd,
  output logic [15:0] frame_data,
  output logic        chk_err,
  output logic        timeout_err
);

  localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT_CYC - 1);
  localparam logic [TO_BIT-1:0] TO_ONE  = TO_BIT'(1);

  logic [1:0]        rst_sync_q;
  logic              run_s;

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        dhi_q, dhi_d;
  logic [7:0]        dlo_q, dlo_d;
  logic [TO_BIT-1:0] to_q, to_d;
  logic              rd_uart_q, rd_uart_d;
  logic              frame_valid_q, frame_valid_d;
  logic              chk_err_q, chk_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        frame_cmd_q, frame_cmd_d;
  logic [15:0]       frame_data_q, frame_data_d;

  // Reset release is re-timed to clk; assertion still acts immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_s = rst_sync_q[1];

  // Next-state logic. A pop request is issued one cycle, and the byte is
  // consumed in the following cycle while rd_uart is high.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    dhi_d         = dhi_q;
    dlo_d         = dlo_q;
    to_d          = to_q;
    rd_uart_d     = 1'b0;
    frame_valid_d = 1'b0;
    chk_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    frame_cmd_d   = frame_cmd_q;
    frame_data_d  = frame_data_q;

    if (!run_s) begin
      state_d = IDLE;
      cmd_d   = 8'h00;
      dhi_d   = 8'h00;
      dlo_d   = 8'h00;
      to_d    = '0;
    end else begin
      rd_uart_d = ~rx_empty & ~rd_uart_q;
      if (rd_uart_q) begin
        to_d = '0;
        case (state_q)
          IDLE: begin
            if (r_data == SOF) begin
              state_d = GET_CMD;
            end else begin
              state_d = IDLE;
            end
          end
          GET_CMD: begin
            cmd_d   = r_data;
            state_d = GET_DHI;
          end
          GET_DHI: begin
            dhi_d   = r_data;
            state_d = GET_DLO;
          end
          GET_DLO: begin
            dlo_d   = r_data;
            state_d = GET_CHK;
          end
          GET_CHK: begin
            state_d = IDLE;
            if (r_data == frame_chk(cmd_q, dhi_q, dlo_q)) begin
              frame_valid_d = 1'b1;
              frame_cmd_d   = cmd_q;
              frame_data_d  = {dhi_q, dlo_q};
            end else begin
              chk_err_d = 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end else if (state_q == IDLE) begin
        to_d = '0;
      end else if ((to_q == TO_LAST) && rx_empty) begin
        // A byte arriving on the expiry cycle suppresses the timeout.
        timeout_err_d = 1'b1;
        state_d       = IDLE;
        to_d          = '0;
      end else begin
        to_d = to_q + TO_ONE;
      end
    end
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cmd_q         <= 8'h00;
      dhi_q         <= 8'h00;
      dlo_q         <= 8'h00;
      to_q          <= '0;
      rd_uart_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      chk_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cmd_q   <= 8'h00;
      frame_data_q  <= 16'h0000;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      dhi_q         <= dhi_d;
      dlo_q         <= dlo_d;
      to_q          <= to_d;
      rd_uart_q     <= rd_uart_d;
      frame_valid_q <= frame_valid_d;
      chk_err_q     <= chk_err_d;
      timeout_err_q <= timeout_err_d;
      frame_cmd_q   <= frame_cmd_d;
      frame_data_q  <= frame_data_d;
    end
  end

  assign rd_uart     = rd_uart_q;
  assign frame_valid = frame_valid_q;
  assign chk_err     = chk_err_q;
  assign timeout_err = timeout_err_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_data  = frame_data_q;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: a byte queue models the UART buffer,
// expected frame events go into a scoreboard queue and are popped on each pulse.
module tb_uart_frame_rx;

  localparam int TO = 300;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_CHK   = 2'd1;
  localparam logic [1:0] K_TMO   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  cmd;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        rd_uart;
  logic        frame_valid;
  logic [7:0]  frame_cmd;
  logic [15:0] frame_data;
  logic        chk_err;
  logic        timeout_err;

  logic [7:0] rxq[$];
  exp_t       expq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int rd_cnt = 0;
  int tmo_gap = 0;
  logic prev_rd = 1'b0;
  logic pop_pending = 1'b0;

  uart_frame_rx #(.SOF(8'hA5), .TIMEOUT_CYC(TO), .TO_BIT(16)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
    .rd_uart(rd_uart), .frame_valid(frame_valid), .frame_cmd(frame_cmd),
    .frame_data(frame_data), .chk_err(chk_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic update_inputs();
    rx_empty = (rxq.size() == 0);
    r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4);
    rxq.push_back(b0); rxq.push_back(b1); rxq.push_back(b2);
    rxq.push_back(b3); rxq.push_back(b4);
    update_inputs();
  endtask

  // One clock: the buffer pops after an edge where rd_uart was high; outputs sampled at negedge.
  task automatic tick();
    exp_t e;
    logic [1:0] obs;
    @(posedge clk);
    #1;
    if (pop_pending && rxq.size() != 0) void'(rxq.pop_front());
    pop_pending = 1'b0;
    update_inputs();
    @(negedge clk);
    cyc++;
    if (rd_uart === 1'b1) begin
      checks++;
      if (prev_rd === 1'b1) begin
        errors++;
        $display("FAIL rd_consecutive: rd_uart high two cycles at cycle %0d, required single-cycle", cyc);
      end
      rd_cnt++;
      last_rd_cyc = cyc;
      pop_pending = 1'b1;
    end
    prev_rd = rd_uart;
    if (frame_valid || chk_err || timeout_err) begin
      checks++;
      if ($countones({frame_valid, chk_err, timeout_err}) != 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got valid/chk/tmo=%b%b%b, required one-hot",
                 frame_valid, chk_err, timeout_err);
      end
      obs = frame_valid ? K_VALID : (chk_err ? K_CHK : K_TMO);
      if (timeout_err) tmo_gap = cyc - last_rd_cyc;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", obs, cyc);
      end else begin
        e = expq.pop_front();
        checks++;
        if (obs !== e.kind) begin
          errors++;
          $display("FAIL event_kind: got %0d, required %0d", obs, e.kind);
        end
        checks++;
        if (frame_cmd !== e.cmd) begin
          errors++;
          $display("FAIL frame_cmd: got %h, required %h", frame_cmd, e.cmd);
        end
        checks++;
        if (frame_data !== e.data) begin
          errors++;
          $display("FAIL frame_data: got %h, required %h", frame_data, e.data);
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rxq.size() != 0 || expq.size() != 0 || pop_pending) && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks++;
    if (expq.size() != 0 || rxq.size() != 0) begin
      errors++;
      $display("FAIL drain_budget: %0d events and %0d bytes left, required 0 and 0",
               expq.size(), rxq.size());
      expq.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({rd_uart, frame_valid, chk_err, timeout_err} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_strobes: got rd/valid/chk/tmo=%b%b%b%b, required 0000",
               tag, rd_uart, frame_valid, chk_err, timeout_err);
    end
    checks++;
    if (frame_cmd !== 8'h00) begin
      errors++;
      $display("FAIL %s_cmd: got %h, required 00", tag, frame_cmd);
    end
    checks++;
    if (frame_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s_data: got %h, required 0000", tag, frame_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    update_inputs();
    #1;
    check_reset_outputs("reset");
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    check_reset_outputs("after_release");
  endtask

  task automatic test_good_frame();
    int rd0 = rd_cnt;
    push_bytes(8'hA5, 8'h12, 8'h34, 8'h56, 8'h70);
    expq.push_back('{K_VALID, 8'h12, 16'h3456});
    drain(100);
    checks++;
    if (rd_cnt - rd0 != 5) begin
      errors++;
      $display("FAIL good_rd_count: got %0d, required 5", rd_cnt - rd0);
    end
  endtask

  task automatic test_discard();
    int rd0 = rd_cnt;
    rxq.push_back(8'h00);
    rxq.push_back(8'hFF);
    push_bytes(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00);
    expq.push_back('{K_VALID, 8'h01, 16'h0203});
    drain(100);
    checks++;
    if (rd_cnt - rd0 != 7) begin
      errors++;
      $display("FAIL discard_rd_count: got %0d, required 7", rd_cnt - rd0);
    end
  endtask

  task automatic test_chk_err();
    push_bytes(8'hA5, 8'h01, 8'h02, 8'h03, 8'hFF);
    expq.push_back('{K_CHK, 8'h01, 16'h0203});
    drain(100);
    checks++;
    if (frame_cmd !== 8'h01 || frame_data !== 16'h0203) begin
      errors++;
      $display("FAIL chk_hold: got %h/%h, required 01/0203", frame_cmd, frame_data);
    end
  endtask

  task automatic test_timeout();
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    update_inputs();
    expq.push_back('{K_TMO, 8'h01, 16'h0203});
    drain(TO + 50);
    checks++;
    if (tmo_gap != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles, required %0d", tmo_gap, TO + 1);
    end
    repeat (TO + 20) tick();
    push_bytes(8'hA5, 8'h10, 8'h20, 8'h30, 8'h00);
    expq.push_back('{K_VALID, 8'h10, 16'h2030});
    drain(100);
  endtask

  task automatic test_timeout_race();
    int target;
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    update_inputs();
    drain(50);
    target = last_rd_cyc + TO;
    while (cyc < target) tick();
    rxq.push_back(8'h02);
    rxq.push_back(8'h03);
    rxq.push_back(8'h00);
    update_inputs();
    expq.push_back('{K_VALID, 8'h01, 16'h0203});
    drain(100);
  endtask

  task automatic test_back_to_back();
    int rd0 = rd_cnt;
    int start;
    int n = 0;
    push_bytes(8'hA5, 8'h12, 8'h34, 8'h56, 8'h70);
    push_bytes(8'hA5, 8'h01, 8'h02, 8'h03, 8'h00);
    expq.push_back('{K_VALID, 8'h12, 16'h3456});
    expq.push_back('{K_VALID, 8'h01, 16'h0203});
    while (rd_cnt == rd0 && n < 20) begin
      tick();
      n++;
    end
    start = last_rd_cyc;
    drain(100);
    checks++;
    if (rd_cnt - rd0 != 10) begin
      errors++;
      $display("FAIL b2b_rd_count: got %0d, required 10", rd_cnt - rd0);
    end
    checks++;
    if (last_rd_cyc - start != 18) begin
      errors++;
      $display("FAIL b2b_rd_spacing: got span %0d, required 18", last_rd_cyc - start);
    end
  endtask

  task automatic test_reset_mid();
    int rd0 = rd_cnt;
    int n = 0;
    rxq.push_back(8'hA5);
    rxq.push_back(8'h01);
    rxq.push_back(8'h02);
    update_inputs();
    while (rd_cnt - rd0 < 3 && n < 50) begin
      tick();
      n++;
    end
    tick();
    reset = 1'b0;
    rxq.delete();
    pop_pending = 1'b0;
    update_inputs();
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) tick();
    push_bytes(8'hA5, 8'hAA, 8'h00, 8'h00, 8'hAA);
    expq.push_back('{K_VALID, 8'hAA, 16'h0000});
    drain(100);
  endtask

  initial begin
    reset = 1'b0;
    rx_empty = 1'b1;
    r_data = 8'h00;
    test_reset();
    test_good_frame();
    test_discard();
    test_chk_err();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d events left, required 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
